// File: rtl/uart_tx_framer.sv
// UART transmit framer: serialises one character into a fixed 11-bit-time frame
// (start, 7/8 data bits LSB first, optional parity, mark fill), paced by BTU ticks.
module uart_tx_framer (
  input  logic       clk,
  input  logic       reset,
  input  logic       Load,
  input  logic [7:0] Data,
  input  logic       Eight,
  input  logic       Parity_En,
  input  logic       Odd_Even,
  input  logic       BTU,
  output logic       Start,
  output logic       Tx,
  output logic       TxRdy,
  output logic       dbg_state,
  output logic [3:0] dbg_bit_cnt
);

  // Handshake: Load is a single-cycle request, accepted only on an edge where
  // TxRdy=1; any Load seen while TxRdy=0 is dropped, never queued.

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [3:0] LAST_BIT = 4'd10;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       eight_q, eight_d;
  logic       par_en_q, par_en_d;
  logic       odd_q, odd_d;
  logic       tx_q, tx_d;

  // Line level for frame position idx, taken from the latched character/config.
  function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] d,
                                     input logic e, input logic pe, input logic oe);
    logic [3:0] nbits;
    logic       par;
    nbits = e ? 4'd8 : 4'd7;
    par   = (^(d & {e, 7'h7f})) ^ oe;
    if (idx == 4'd0)
      frame_bit = 1'b0;
    else if (idx <= nbits)
      frame_bit = d[3'(idx - 4'd1)];
    else if (pe && (idx == nbits + 4'd1))
      frame_bit = par;
    else
      frame_bit = 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      data_q   <= 8'd0;
      eight_q  <= 1'b0;
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      eight_q  <= eight_d;
      par_en_q <= par_en_d;
      odd_q    <= odd_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    eight_d  = eight_q;
    par_en_d = par_en_q;
    odd_d    = odd_q;
    tx_d     = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (Load) begin
          state_d  = SEND;
          cnt_d    = 4'd0;
          data_d   = Data;
          eight_d  = Eight;
          par_en_d = Parity_En;
          odd_d    = Odd_Even;
          tx_d     = 1'b0;
        end
      end
      SEND: begin
        if (BTU) begin
          if (cnt_q == LAST_BIT) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            tx_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            tx_d  = frame_bit(cnt_q + 4'd1, data_q, eight_q, par_en_q, odd_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign Tx          = tx_q;
  assign Start       = (state_q == SEND);
  assign TxRdy       = (state_q == IDLE);
  assign dbg_state   = state_q;
  assign dbg_bit_cnt = cnt_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: table of characters/configs with hand-derived frames,
// plus hand sequences for ignored Loads, idle BTUs and mid-frame reset.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] data;
  logic       eight, parity_en, odd_even, btu;
  logic       start, tx, txrdy, dbg_state;
  logic [3:0] dbg_bit_cnt;

  int total = 0;
  int bad   = 0;

  logic [0:0] exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic        eight;
    logic        pe;
    logic        oe;
    logic [0:10] bits;
  } vec_t;

  vec_t vecs[8];

  uart_tx_framer dut (
    .clk(clk), .reset(reset), .Load(load), .Data(data), .Eight(eight),
    .Parity_En(parity_en), .Odd_Even(odd_even), .BTU(btu),
    .Start(start), .Tx(tx), .TxRdy(txrdy),
    .dbg_state(dbg_state), .dbg_bit_cnt(dbg_bit_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_tx"}, 11'(tx), 11'd1);
    chk({name, "_start"}, 11'(start), 11'd0);
    chk({name, "_txrdy"}, 11'(txrdy), 11'd1);
  endtask

  // Drives one frame from vecs[idx]; BTU every `period` clocks. disturb scrambles
  // inputs and pulses Load mid-frame and on the final BTU. btu_on_load raises BTU
  // together with the accepted Load.
  task automatic do_frame(input int idx, input int period, input bit disturb,
                          input bit btu_on_load);
    logic [0:0] e;
    data = vecs[idx].data; eight = vecs[idx].eight;
    parity_en = vecs[idx].pe; odd_even = vecs[idx].oe;
    load = 1'b1; btu = btu_on_load;
    tick();
    load = 1'b0; btu = 1'b0;
    for (int k = 0; k < 11; k++) exp_q.push_back(vecs[idx].bits[k]);
    for (int b = 0; b < 11; b++) begin
      if (exp_q.size() == 0) begin
        chk("queue_underrun", 11'd0, 11'd1);
        e = 1'b1;
      end else e = exp_q.pop_front();
      chk($sformatf("v%0d_bit%0d", idx, b), 11'(tx), 11'(e));
      chk($sformatf("v%0d_busy%0d", idx, b), {9'd0, start, txrdy}, 11'b10);
      if (disturb) begin
        data = 8'($urandom); eight = 1'($urandom); parity_en = 1'($urandom);
        odd_even = 1'($urandom);
        if (b == 5) load = 1'b1;
      end
      for (int c = 0; c < period - 1; c++) begin
        tick();
        load = 1'b0;
      end
      chk($sformatf("v%0d_hold%0d", idx, b), 11'(tx), 11'(e));
      btu = 1'b1;
      if (disturb && b == 10) load = 1'b1;
      tick();
      btu = 1'b0; load = 1'b0;
    end
    chk_idle($sformatf("v%0d_end", idx));
  endtask

  initial begin
    // bits listed start-bit first
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 11'b01010010101};
    vecs[1] = '{8'h41, 1'b0, 1'b0, 1'b0, 11'b01000001111};
    vecs[2] = '{8'hC1, 1'b0, 1'b0, 1'b0, 11'b01000001111};
    vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b1, 11'b01110000001};
    vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b0, 11'b01110000011};
    vecs[5] = '{8'h55, 1'b1, 1'b0, 1'b0, 11'b01010101011};
    vecs[6] = '{8'h03, 1'b0, 1'b1, 1'b0, 11'b01100000011};
    vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b1, 11'b01111111011};

    reset = 1'b1; load = 1'b0; data = 8'h00; eight = 1'b0;
    parity_en = 1'b0; odd_even = 1'b0; btu = 1'b0;
    tick(); tick();
    chk_idle("reset");
    chk("reset_cnt", 11'(dbg_bit_cnt), 11'd0);
    reset = 1'b0;
    tick();

    // BTU pulses while idle change nothing
    for (int i = 0; i < 3; i++) begin
      btu = 1'b1; tick(); btu = 1'b0;
      chk_idle("idle_btu");
      tick();
    end

    // table: each frame launched in the first idle cycle after the previous one
    for (int i = 0; i < 8; i++) begin
      do_frame(i, (i == 0) ? 16 : $urandom_range(2, 6), 1'b0, 1'b0);
    end

    // Load mid-frame and on final BTU ignored; then back-to-back accept
    do_frame(0, 4, 1'b1, 1'b0);
    do_frame(7, 3, 1'b0, 1'b0);

    // Load coincident with BTU: start bit still lasts a full bit time
    tick();
    do_frame(3, 5, 1'b0, 1'b1);
    do_frame(4, 1, 1'b0, 1'b0);

    // reset after the 4th BTU aborts the frame; reset beats Load and BTU
    data = vecs[0].data; eight = 1'b1; parity_en = 1'b1; odd_even = 1'b0;
    load = 1'b1; tick(); load = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("abort_bit%0d", b), 11'(tx), 11'(vecs[0].bits[b]));
      repeat (3) tick();
      btu = 1'b1; tick(); btu = 1'b0;
    end
    chk("abort_bit4", 11'(tx), 11'(vecs[0].bits[4]));
    chk("abort_cnt", 11'(dbg_bit_cnt), 11'd4);
    reset = 1'b1; load = 1'b1; btu = 1'b1;
    tick();
    reset = 1'b0; load = 1'b0; btu = 1'b0;
    chk_idle("abort");
    chk("abort_cnt_clr", 11'(dbg_bit_cnt), 11'd0);
    tick();
    chk_idle("abort_idle");
    do_frame(5, 4, 1'b0, 1'b0);

    chk("queue_empty", 11'(exp_q.size()), 11'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
